alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 64, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  arbiter accepts requester 0 this cycle.
REQ-006 req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-007 req0_op  input  3  requester 0 ALU operation code.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op: same as REQ-004..007, requester 1.
REQ-009 alu_a, alu_b  output  WIDTH each  registered operands to shared ALU.
REQ-010 alu_op  output  3  registered operation code to shared ALU.
REQ-011 alu_result  input  WIDTH  combinational result from shared ALU.
REQ-012 rsp0_valid, rsp1_valid  output  1 each  one-cycle response strobe per requester.
REQ-013 rsp_result  output  WIDTH  registered result, shared by both responses.
REQ-014 rsp_err  output  1  strobes with rsp*_valid when op code was illegal.

Function
REQ-015 Op codes: 000 add, 001 sub, 010 and, 011 or, 100 shift right, 101 shift left; 110/111 illegal.
REQ-016 Two states: IDLE (may accept), ISSUE (operation in ALU); no other states.
REQ-017 Handshake: transfer occurs in a cycle where reqN_valid and reqN_ready are both high.
REQ-018 reqN_ready combinational; high only in IDLE and only for the granted requester; never both high.
REQ-019 Grant in IDLE: only one valid -> that one; both valid -> the requester not granted last (round-robin).
REQ-020 last_grant register updates only on a handshake; reset value 1 so requester 0 wins the first tie.
REQ-021 Requesters hold valid, operands and op stable until handshake; arbiter does not buffer unaccepted requests.
REQ-022 Handshake in cycle T: IDLE->ISSUE; alu_a/alu_b/alu_op carry the accepted operands unmodified during T+1.
REQ-023 End of T+1: capture alu_result into rsp_result; ISSUE->IDLE.
REQ-024 Cycle T+2: rspN_valid high exactly one cycle for the accepted requester; other rsp valid stays low.
REQ-025 Latency handshake-to-response is 2 cycles; max throughput one operation per 2 cycles.
REQ-026 In T+2 the arbiter is in IDLE and may accept a new request (back-to-back issue allowed).
REQ-027 Illegal op: alu_op driven as received, rsp_result forced to 0, rsp_err high with rspN_valid.
REQ-028 rsp_result and rsp_err hold last value when no response strobe (don't-care to requesters).
REQ-029 No response back-pressure; requesters must accept rspN_valid whenever it occurs.
REQ-030 alu_a/alu_b/alu_op hold last issued values while IDLE.

Reset
REQ-031 With rst_n low at a rising edge: state IDLE, last_grant 1, alu_a/alu_b 0, alu_op 000, rsp_result 0, rsp0_valid/rsp1_valid/rsp_err 0.
REQ-032 Reset during ISSUE or response cycle discards the operation; no response strobe follows.
REQ-033 reqN_ready low throughout reset cycles regardless of reqN_valid.

Verification
REQ-034 req0 add A=5,B=3 alone -> req0_ready high at T, alu_op=000 at T+1, rsp0_valid and rsp_result=8 at T+2, rsp_err 0.
REQ-035 Both valid after reset, req0 sub 10-4, req1 or 0xF0|0x0F -> req0 first: rsp0 result 6; req1 accepted next IDLE, rsp1 result 0xFF; then req0 again wins next tie only after req1.
REQ-036 req1 shift left A=1,B=4 held continuously 3 ops -> handshakes every 2 cycles, rsp1 results 16 each, no gaps beyond 1 cycle.
REQ-037 req0 op 111 A=9,B=9 -> rsp0_valid with rsp_result 0 and rsp_err 1 at T+2.
REQ-038 rst_n low in cycle T+1 after req0 handshake -> no rsp0_valid in T+2, all outputs at reset values, next tie grants req0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Each accepted operation is issued for one cycle, and its response strobes two cycles after the handshake.
module alu_arbiter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0] state;
  logic       last_grant;
  logic       issue_id;
  logic       grant;
  logic       hs0;
  logic       hs1;
  logic       illegal;

  // On a tie, the requester that did not win last time gets the grant; otherwise whichever requester is valid wins.
  always_comb begin
    grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
    req1_ready = rst_n && (state == IDLE) && req1_valid && grant;
    hs0        = req0_valid && req0_ready;
    hs1        = req1_valid && req1_ready;
    illegal    = (alu_op[2:1] == 2'b11);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      issue_id   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (state == ISSUE) begin
        state      <= IDLE;
        rsp_result <= illegal ? '0 : alu_result;
        rsp_err    <= illegal;
        rsp0_valid <= !issue_id;
        rsp1_valid <= issue_id;
      end else if (hs0 || hs1) begin
        state      <= ISSUE;
        last_grant <= hs1;
        issue_id   <= hs1;
        alu_a      <= hs1 ? req1_a  : req0_a;
        alu_b      <= hs1 ? req1_b  : req0_b;
        alu_op     <= hs1 ? req1_op : req0_op;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. It uses table-driven single-requester vectors, tie/round-robin sequences,
// held-valid throughput and reset-abort cases, with a per-requester scoreboard of expected responses.
module tb_alu_arbiter;

  typedef struct {
    int          id;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic [63:0] res;
    logic        err;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic [63:0] alu_a, alu_b, alu_result, rsp_result;
  logic [2:0]  alu_op;
  logic        rsp0_valid, rsp1_valid, rsp_err;

  int ntotal = 0;
  int npass  = 0;
  int cyc    = 0;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   hs_order[$];
  int   hs_cyc[$];

  logic        fl_valid = 1'b0;
  int          fl_id, fl_due;
  exp_t        fl_exp;
  logic        alu_pend = 1'b0;
  int          alu_due;
  logic [63:0] alu_ea, alu_eb;
  logic [2:0]  alu_eop;

  vec_t vecs[10];

  alu_arbiter #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_result(rsp_result), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The shared ALU; illegal codes return garbage so that forcing the result to zero is observable.
  function automatic logic [63:0] alu_fn(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a >> b;
      3'b101:  return a << b;
      default: return 64'hDEAD_BEEF_0BAD_F00D;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_a, alu_b, alu_op);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntotal++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    else npass++;
  endtask

  task automatic fail_now(input string name, input string msg);
    ntotal++;
    $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
  endtask

  // Monitor: responses are checked before a same-cycle handshake is recorded.
  always @(negedge clk) begin
    if (rsp0_valid || rsp1_valid) begin
      if (!fl_valid) fail_now("rsp_unexpected", "response strobe with no operation in flight");
      else begin
        chk("rsp_valid_onehot", {62'd0, rsp1_valid, rsp0_valid}, (fl_id == 1) ? 64'd2 : 64'd1);
        chk("rsp_latency", cyc, fl_due);
        chk("rsp_result", rsp_result, fl_exp.res);
        chk("rsp_err", {63'd0, rsp_err}, {63'd0, fl_exp.err});
        fl_valid = 1'b0;
      end
    end else if (fl_valid && cyc > fl_due) begin
      fail_now("rsp_missing", "no response strobe two cycles after handshake");
      fl_valid = 1'b0;
    end
    if (alu_pend && cyc == alu_due) begin
      chk("alu_a", alu_a, alu_ea);
      chk("alu_b", alu_b, alu_eb);
      chk("alu_op", {61'd0, alu_op}, {61'd0, alu_eop});
      alu_pend = 1'b0;
    end
    if (req0_ready === 1'b1 || req1_ready === 1'b1)
      chk("ready_not_both", {63'd0, req0_ready && req1_ready}, 64'd0);
    if (rst_n && ((req0_valid && req0_ready) || (req1_valid && req1_ready))) begin
      fl_id = (req1_valid && req1_ready) ? 1 : 0;
      if ((fl_id == 0 && exp_q0.size() == 0) || (fl_id == 1 && exp_q1.size() == 0))
        fail_now("hs_unexpected", "handshake with no expected response queued");
      else begin
        fl_exp   = (fl_id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        fl_valid = 1'b1;
        fl_due   = cyc + 2;
        alu_pend = 1'b1;
        alu_due  = cyc + 1;
        alu_ea   = (fl_id == 0) ? req0_a  : req1_a;
        alu_eb   = (fl_id == 0) ? req0_b  : req1_b;
        alu_eop  = (fl_id == 0) ? req0_op : req1_op;
        hs_order.push_back(fl_id);
        hs_cyc.push_back(cyc);
      end
    end
    if (!rst_n) begin
      fl_valid = 1'b0;
      alu_pend = 1'b0;
    end
  end

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.res = v.res;
    e.err = v.err;
    if (v.id == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  task automatic drive(input vec_t v);
    if (v.id == 0) begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_op = v.op;
    end else begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_op = v.op;
    end
  endtask

  task automatic wait_hs(input int id);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (id == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
    end
    if (!seen) fail_now("hs_timeout", $sformatf("req%0d saw no handshake within 20 cycles", id));
  endtask

  task automatic tie_pair(input vec_t v0, input vec_t v1, input int first);
    bit d0 = 1'b0;
    bit d1 = 1'b0;
    push_exp(v0);
    push_exp(v1);
    drive(v0);
    drive(v1);
    hs_order.delete();
    for (int i = 0; i < 20 && !(d0 && d1); i++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) d0 = 1'b1;
      if (req1_valid && req1_ready) d1 = 1'b1;
      @(posedge clk); #1;
      if (d0) req0_valid = 1'b0;
      if (d1) req1_valid = 1'b0;
    end
    if (!(d0 && d1)) fail_now("tie_timeout", "both requesters not served within 20 cycles");
    if (hs_order.size() == 2) begin
      chk("tie_first", 64'(hs_order[0]), 64'(first));
      chk("tie_second", 64'(hs_order[1]), 64'(1 - first));
    end else fail_now("tie_order", $sformatf("%0d handshakes recorded, 2 required", hs_order.size()));
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t t0, t1, h;
    int   nh;

    vecs[0] = '{id: 0, a: 64'd5, b: 64'd3, op: 3'b000, res: 64'd8, err: 1'b0};
    vecs[1] = '{id: 1, a: 64'd0, b: 64'd1, op: 3'b001, res: 64'hFFFF_FFFF_FFFF_FFFF, err: 1'b0};
    vecs[2] = '{id: 0, a: 64'hF0F0, b: 64'hFF00, op: 3'b010, res: 64'hF000, err: 1'b0};
    vecs[3] = '{id: 1, a: 64'hF0, b: 64'h0F, op: 3'b011, res: 64'hFF, err: 1'b0};
    vecs[4] = '{id: 0, a: 64'h8000_0000_0000_0000, b: 64'd63, op: 3'b100, res: 64'd1, err: 1'b0};
    vecs[5] = '{id: 1, a: 64'd1, b: 64'd63, op: 3'b101, res: 64'h8000_0000_0000_0000, err: 1'b0};
    vecs[6] = '{id: 0, a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd1, op: 3'b000, res: 64'd0, err: 1'b0};
    vecs[7] = '{id: 0, a: 64'd9, b: 64'd9, op: 3'b111, res: 64'd0, err: 1'b1};
    vecs[8] = '{id: 1, a: 64'd7, b: 64'd7, op: 3'b110, res: 64'd0, err: 1'b1};
    vecs[9] = '{id: 0, a: 64'd3, b: 64'd0, op: 3'b101, res: 64'd3, err: 1'b0};
    t0 = '{id: 0, a: 64'd10, b: 64'd4, op: 3'b001, res: 64'd6, err: 1'b0};
    t1 = '{id: 1, a: 64'hF0, b: 64'h0F, op: 3'b011, res: 64'hFF, err: 1'b0};

    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_op = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready0", {63'd0, req0_ready}, 64'd0);
    chk("reset_ready1", {63'd0, req1_ready}, 64'd0);
    chk("reset_alu_a", alu_a, 64'd0);
    chk("reset_alu_b", alu_b, 64'd0);
    chk("reset_alu_op", {61'd0, alu_op}, 64'd0);
    chk("reset_rsp_result", rsp_result, 64'd0);
    chk("reset_rsp_err", {63'd0, rsp_err}, 64'd0);
    chk("reset_rsp_valid", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;

    // The first tie after reset goes to req0, and the next tie goes to req0 again because req1 was granted last.
    tie_pair(t0, t1, 0);
    tie_pair(t0, t1, 0);

    foreach (vecs[k]) begin
      push_exp(vecs[k]);
      drive(vecs[k]);
      wait_hs(vecs[k].id);
      @(posedge clk); #1;
      if (vecs[k].id == 0) req0_valid = 1'b0;
      else req1_valid = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;

    // req0 was granted last, so req1 wins this tie.
    tie_pair(t0, t1, 1);

    h = '{id: 1, a: 64'd1, b: 64'd4, op: 3'b101, res: 64'd16, err: 1'b0};
    repeat (3) push_exp(h);
    hs_cyc.delete();
    drive(h);
    nh = 0;
    for (int i = 0; i < 20 && nh < 3; i++) begin
      @(negedge clk);
      if (req1_valid && req1_ready) nh++;
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    if (hs_cyc.size() == 3) begin
      chk("held_gap1", 64'(hs_cyc[1] - hs_cyc[0]), 64'd2);
      chk("held_gap2", 64'(hs_cyc[2] - hs_cyc[1]), 64'd2);
    end else fail_now("held_count", $sformatf("%0d handshakes recorded, 3 required", hs_cyc.size()));
    repeat (3) @(posedge clk);
    #1;

    // Asserting reset during the issue cycle drops the operation without producing a response.
    h = '{id: 0, a: 64'd2, b: 64'd2, op: 3'b000, res: 64'd4, err: 1'b0};
    push_exp(h);
    drive(h);
    wait_hs(0);
    @(posedge clk); #1;
    rst_n = 1'b0; req1_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_rsp_valid", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
    chk("abort_ready0", {63'd0, req0_ready}, 64'd0);
    chk("abort_ready1", {63'd0, req1_ready}, 64'd0);
    chk("abort_alu_a", alu_a, 64'd0);
    chk("abort_alu_b", alu_b, 64'd0);
    chk("abort_alu_op", {61'd0, alu_op}, 64'd0);
    chk("abort_rsp_result", rsp_result, 64'd0);
    chk("abort_rsp_err", {63'd0, rsp_err}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    tie_pair(t0, t1, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drain_exp_q0", 64'(exp_q0.size()), 64'd0);
    chk("drain_exp_q1", 64'(exp_q1.size()), 64'd0);
    chk("drain_inflight", {63'd0, fl_valid}, 64'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
